// File: rtl/fb_pkg.sv
// Shared widths, pixel layout and default 256x256 raster timing for the framebuffer scanout.
package fb_pkg;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;
    localparam int PIX_W   = 3 * COLOR_W;
    localparam int ADDR_W  = 2 * COORD_W;
    localparam int CNT_W   = 12;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pixel_t;

    localparam int H_ACTIVE_DEF = 256;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 256;
    localparam int V_FRONT_DEF  = 4;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BACK_DEF   = 16;

    function automatic int timing_total(input int act, input int front, input int sync, input int back);
        return act + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel-write input and display-timing output bundle of the framebuffer scanout.
interface fb_scanout_if;
    import fb_pkg::*;

    logic               WE;
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;

    logic               BUSY;
    logic               HSYNC_N;
    logic               VSYNC_N;
    logic               DE;
    logic [COLOR_W-1:0] RO;
    logic [COLOR_W-1:0] GO;
    logic [COLOR_W-1:0] BO;
    logic               FRAME_START;

    modport master (
        output WE, X, Y, R, G, B,
        input  BUSY, HSYNC_N, VSYNC_N, DE, RO, GO, BO, FRAME_START
    );

    modport slave (
        input  WE, X, Y, R, G, B,
        output BUSY, HSYNC_N, VSYNC_N, DE, RO, GO, BO, FRAME_START
    );

endinterface

// File: rtl/fb_ram.sv
// 64K x 9 simple dual-port framebuffer RAM; read data registered (1 clk), read-first on collision.
// No backpressure: one write and one read every clock.
module fb_ram import fb_pkg::*; (
    input  logic              clk,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_dat
);

    pixel_t ram_q [0:(1<<ADDR_W)-1];
    pixel_t rd_dat_q;

    // Both updates are non-blocking, so a same-address read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            ram_q[wr_addr] <= wr_dat;
        end
        rd_dat_q <= ram_q[rd_addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer write port plus raster scanout (syncs, DE, 3:3:3 RGB); 2 clk scan latency, no write backpressure.
// Build option FB_CLEAR_EN: zero the whole framebuffer after reset, holding BUSY and ignoring WE meanwhile.
module fb_scanout import fb_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    fb_scanout_if.slave  vid
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic              run_q, run_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;

    logic              act0, hs0_n, vs0_n, fs0;
    logic [ADDR_W-1:0] rd_addr;
    pixel_t            rd_dat;

    logic              de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
    logic              de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;
    pixel_t            rgb2_q, rgb2_d;

    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_dat;
    logic              busy;

    // The raster holds at (0,0) for the first clock after reset, so pixel (0,0) leaves on the 3rd edge.
    always_comb begin
        run_d  = 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (run_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        act0    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs0_n   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        vs0_n   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
        fs0     = (hcnt_q == '0) && (vcnt_q == '0);
        rd_addr = {vcnt_q[COORD_W-1:0], hcnt_q[COORD_W-1:0]};
    end

    // Stage 1 runs alongside the RAM read; stage 2 is the output register.
    always_comb begin
        de1_d = run_q & act0;
        hs1_d = ~run_q | hs0_n;
        vs1_d = ~run_q | vs0_n;
        fs1_d = run_q & fs0;
        de2_d = de1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        fs2_d = fs1_q;
        if (de1_q) begin
            rgb2_d = rd_dat;
        end else begin
            rgb2_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_q  <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            fs1_q  <= 1'b0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            fs2_q  <= 1'b0;
            rgb2_q <= '0;
        end else begin
            run_q  <= run_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            de1_q  <= de1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            fs1_q  <= fs1_d;
            de2_q  <= de2_d;
            hs2_q  <= hs2_d;
            vs2_q  <= vs2_d;
            fs2_q  <= fs2_d;
            rgb2_q <= rgb2_d;
        end
    end

`ifdef FB_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // done_q only survives until the next reset, which is what restarts an interrupted sweep at 0.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_IDLE) begin
            if (!done_q) begin
                state_d = ST_CLEAR;
            end
        end else begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        wr_vld  = vid.WE;
        wr_addr = {vid.Y, vid.X};
        wr_dat  = {vid.R, vid.G, vid.B};
`ifdef FB_CLEAR_EN
        if (busy) begin
            wr_vld  = 1'b1;
            wr_addr = clr_addr_q;
            wr_dat  = '0;
        end
`endif
    end

    fb_ram u_ram (
        .clk     (CLK),
        .wr_vld  (wr_vld),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    assign vid.BUSY        = busy;
    assign vid.HSYNC_N     = hs2_q;
    assign vid.VSYNC_N     = vs2_q;
    assign vid.DE          = de2_q;
    assign vid.FRAME_START = fs2_q;
    assign vid.RO          = rgb2_q.r;
    assign vid.GO          = rgb2_q.g;
    assign vid.BO          = rgb2_q.b;

endmodule
